// File: rtl/sm_result_pkg.sv
// Shared definitions for the stack machine result collector: error codes,
// collector FSM encoding, record widths and a saturating-increment helper.
package sm_result_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int ERR_W      = 3;
  localparam int SEQ_W      = 8;
  localparam int REC_W      = DATA_W_DEF + ERR_W + SEQ_W;

  localparam logic [ERR_W-1:0] ERR_OK      = 3'b000;
  localparam logic [ERR_W-1:0] ERR_STK     = 3'b001;
  localparam logic [ERR_W-1:0] ERR_UND     = 3'b010;
  localparam logic [ERR_W-1:0] ERR_RESTORE = 3'b100;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sm_result_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit
// so full and empty are distinguished without an occupancy counter.
module sm_result_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  // Storage is cleared on reset so the head outputs read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sm_result_collector.sv
// Result collector: tags and queues stack machine results, counts categories,
// hands records to a host. Optional checksum: SM_RESULT_COLLECTOR_CHKSUM_EN.
module sm_result_collector
  import sm_result_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] out_data,
  input  logic [2:0]        err_code,
  input  logic              fin,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [2:0]        o_err,
  output logic [7:0]        o_seq,
  output logic [7:0]        ok_cnt,
  output logic [7:0]        stk_cnt,
  output logic [7:0]        und_cnt,
  output logic [7:0]        rst_cnt,
  output logic [7:0]        drop_cnt,
  output logic              done,
  output logic [DATA_W-1:0] chksum,
  output logic [1:0]        state_dbg
);

  localparam int RW = DATA_W + ERR_W + SEQ_W;

  // Host handshake: a record transfers on any cycle with o_valid && o_ready;
  // o_valid never depends on o_ready, and the head holds until accepted.
  logic          full, empty, push, pop, drop;
  logic [RW-1:0] rd_rec;
  logic [7:0]    seq;
  state_t        state, state_nxt;

  assign o_valid = !empty;
  assign pop     = o_valid && o_ready;
  assign push    = d_valid && (!full || pop);
  assign drop    = d_valid && full && !pop;

  sm_result_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({out_data, err_code, seq}),
    .rd_data (rd_rec),
    .full    (full),
    .empty   (empty)
  );

  assign {o_data, o_err, o_seq} = rd_rec;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= '0;
      ok_cnt   <= '0;
      stk_cnt  <= '0;
      und_cnt  <= '0;
      rst_cnt  <= '0;
      drop_cnt <= '0;
    end else if (d_valid) begin
      seq <= seq + 8'd1;
      case (err_code)
        ERR_OK:      ok_cnt  <= sat_inc(ok_cnt);
        ERR_STK:     stk_cnt <= sat_inc(stk_cnt);
        ERR_RESTORE: rst_cnt <= sat_inc(rst_cnt);
        default:     und_cnt <= sat_inc(und_cnt);
      endcase
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // RUN is left only once; fin is treated as sticky by never returning.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (fin) state_nxt = DRAIN;
      DRAIN:   if (empty && !push) state_nxt = DONE;
      DONE:    if (d_valid) state_nxt = DRAIN;
      default: state_nxt = RUN;
    endcase
  end

  assign done      = (state == DONE);
  assign state_dbg = state;

`ifdef SM_RESULT_COLLECTOR_CHKSUM_EN
  // Dropped ok results still contribute, so the sum reflects everything produced.
  always_ff @(posedge clk) begin
    if (rst)                             chksum <= '0;
    else if (d_valid && err_code == ERR_OK) chksum <= chksum + out_data;
  end
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_sm_result_collector.sv
// Self-checking bench for sm_result_collector: table-driven vectors plus
// hand-written multi-cycle sequences with a record scoreboard.
module tb_sm_result_collector;
  import sm_result_pkg::*;

  localparam int DW = 20;
  localparam int RW = DW + 3 + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          d_valid = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic [2:0]    err_code = '0;
  logic          fin = 1'b0;
  logic          o_ready = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [2:0]    o_err;
  logic [7:0]    o_seq;
  logic [7:0]    ok_cnt, stk_cnt, und_cnt, rst_cnt, drop_cnt;
  logic          done;
  logic [DW-1:0] chksum;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic sb_en = 1'b0;
  logic [RW-1:0] exp_q[$];

  sm_result_collector #(.DEPTH(8), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .out_data(out_data),
    .err_code(err_code), .fin(fin), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_err(o_err), .o_seq(o_seq), .ok_cnt(ok_cnt),
    .stk_cnt(stk_cnt), .und_cnt(und_cnt), .rst_cnt(rst_cnt),
    .drop_cnt(drop_cnt), .done(done), .chksum(chksum), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: score the head if it transfers this edge, then step past the edge.
  task automatic cycle();
    logic [RW-1:0] e;
    if (sb_en && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got seq %0h expected no record", o_seq);
      end else begin
        e = exp_q.pop_front();
        check("sb_rec", 32'({o_data, o_err, o_seq}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    rst = 1'b1; d_valid = 1'b0; fin = 1'b0; o_ready = 1'b0;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [2:0] e);
    d_valid = 1'b1; out_data = d; err_code = e;
    cycle();
    d_valid = 1'b0;
  endtask

  task automatic expect_rec(input logic [DW-1:0] d, input logic [2:0] e, input logic [7:0] s);
    exp_q.push_back({d, e, s});
  endtask

  task automatic drain(input string name);
    o_ready = 1'b1; d_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cycle();
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_empty"}, 32'(o_valid), 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ovalid"}, 32'(o_valid), 0);
    check({name, "_odata"}, 32'(o_data), 0);
    check({name, "_oerr"}, 32'(o_err), 0);
    check({name, "_oseq"}, 32'(o_seq), 0);
    check({name, "_cnts"}, {ok_cnt, stk_cnt, und_cnt, rst_cnt}, 0);
    check({name, "_drop"}, 32'(drop_cnt), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_chk"}, 32'(chksum), 0);
    check({name, "_state"}, 32'(state_dbg), 32'(RUN));
  endtask

  typedef struct {
    logic          dv;
    logic [DW-1:0] d;
    logic [2:0]    e;
    logic          ov;
    logic [DW-1:0] od;
    logic [2:0]    oe;
    logic [7:0]    os;
    logic [7:0]    ok, stk, und, rc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 20'd5,       3'b000, 1'b1, 20'd5,       3'b000, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    vecs[1] = '{1'b1, 20'hFFFFD,   3'b000, 1'b1, 20'hFFFFD,   3'b000, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0};
    vecs[2] = '{1'b1, 20'd42,      3'b000, 1'b1, 20'd42,      3'b000, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0};
    vecs[3] = '{1'b1, 20'd7,       3'b001, 1'b1, 20'd7,       3'b001, 8'd3, 8'd3, 8'd1, 8'd0, 8'd0};
    vecs[4] = '{1'b1, 20'd8,       3'b010, 1'b1, 20'd8,       3'b010, 8'd4, 8'd3, 8'd1, 8'd1, 8'd0};
    vecs[5] = '{1'b1, 20'd9,       3'b100, 1'b1, 20'd9,       3'b100, 8'd5, 8'd3, 8'd1, 8'd1, 8'd1};
    vecs[6] = '{1'b1, 20'd10,      3'b111, 1'b1, 20'd10,      3'b111, 8'd6, 8'd3, 8'd1, 8'd2, 8'd1};
    vecs[7] = '{1'b0, 20'd0,       3'b000, 1'b0, 20'd0,       3'b000, 8'd0, 8'd3, 8'd1, 8'd2, 8'd1};

    // reset state
    do_reset();
    check_zero("reset");

    // table: ok results then each error category, host always ready
    sb_en = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_valid = vecs[i].dv; out_data = vecs[i].d; err_code = vecs[i].e;
      cycle();
      check($sformatf("vec%0d_ovalid", i), 32'(o_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        check($sformatf("vec%0d_odata", i), 32'(o_data), 32'(vecs[i].od));
        check($sformatf("vec%0d_oerr", i), 32'(o_err), 32'(vecs[i].oe));
        check($sformatf("vec%0d_oseq", i), 32'(o_seq), 32'(vecs[i].os));
      end
      check($sformatf("vec%0d_cnts", i), {ok_cnt, stk_cnt, und_cnt, rst_cnt},
            {vecs[i].ok, vecs[i].stk, vecs[i].und, vecs[i].rc});
    end
    d_valid = 1'b0;
`ifdef SM_RESULT_COLLECTOR_CHKSUM_EN
    check("vec_chksum", 32'(chksum), 32'h0002C);
`else
    check("vec_chksum", 32'(chksum), 32'h0);
`endif

    // overflow: 10 results into a stalled 8-entry queue
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(20'(100 + i), ERR_OK);
      if (i < 8) expect_rec(20'(100 + i), ERR_OK, 8'(i));
    end
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    check("ovf_ok", 32'(ok_cnt), 32'd10);
    cycle();
    check("ovf_hold_valid", 32'(o_valid), 32'd1);
    check("ovf_hold_head", 32'({o_data, o_seq}), 32'({20'd100, 8'd0}));
    drain("ovf");
    send(20'd300, ERR_OK);
    expect_rec(20'd300, ERR_OK, 8'd10);
    drain("ovf_next");

    // full queue with simultaneous push and pop
    o_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(20'(400 + i), ERR_OK);
      expect_rec(20'(400 + i), ERR_OK, 8'(11 + i));
    end
    check("full_drop0", 32'(drop_cnt), 32'd2);
    o_ready = 1'b1;
    send(20'd500, ERR_OK);
    expect_rec(20'd500, ERR_OK, 8'd19);
    check("full_pushpop_drop", 32'(drop_cnt), 32'd2);
    o_ready = 1'b0;
    send(20'd600, ERR_OK);
    check("full_still8_drop", 32'(drop_cnt), 32'd3);
    drain("full");

    // fin with empty queue: done two edges later
    do_reset();
    fin = 1'b1;
    cycle();
    check("fin_min_done1", 32'(done), 32'd0);
    cycle();
    check("fin_min_done2", 32'(done), 32'd1);

    // fin with two queued records
    do_reset();
    send(20'd11, ERR_OK); expect_rec(20'd11, ERR_OK, 8'd0);
    send(20'd12, ERR_OK); expect_rec(20'd12, ERR_OK, 8'd1);
    fin = 1'b1; o_ready = 1'b1;
    cycle();
    check("fin_done_a", 32'(done), 32'd0);
    check("fin_state_a", 32'(state_dbg), 32'(DRAIN));
    cycle();
    check("fin_done_b", 32'(done), 32'd0);
    check("fin_empty_b", 32'(o_valid), 32'd0);
    cycle();
    check("fin_done_c", 32'(done), 32'd1);
    send(20'd77, ERR_OK); expect_rec(20'd77, ERR_OK, 8'd2);
    check("redo_done_drop", 32'(done), 32'd0);
    check("redo_valid", 32'(o_valid), 32'd1);
    cycle();
    check("redo_done_mid", 32'(done), 32'd0);
    cycle();
    check("redo_done_back", 32'(done), 32'd1);
    check("redo_left", 32'(exp_q.size()), 32'd0);
    fin = 1'b0;

    // 300 results: saturation and sequence wrap
    do_reset();
    o_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(20'(i), ERR_OK);
      expect_rec(20'(i), ERR_OK, 8'(i));
    end
    drain("sat");
    check("sat_ok", 32'(ok_cnt), 32'd255);
`ifdef SM_RESULT_COLLECTOR_CHKSUM_EN
    check("sat_chksum", 32'(chksum), 32'h0AF32);
`else
    check("sat_chksum", 32'(chksum), 32'h0);
`endif
    o_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(20'd1, ERR_OK);
    check("sat_ok_hold", 32'(ok_cnt), 32'd255);
    check("sat_drop", 32'(drop_cnt), 32'd2);

    // reset mid-stream with a result present
    sb_en = 1'b0;
    rst = 1'b1; d_valid = 1'b1; out_data = 20'd5; err_code = ERR_OK;
    cycle();
    rst = 1'b0; d_valid = 1'b0;
    check_zero("midrst");
    exp_q.delete();
    sb_en = 1'b1;
    send(20'd9, ERR_OK); expect_rec(20'd9, ERR_OK, 8'd0);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_result_collector.md
# sm_result_collector

Receiving end of the stack machine's result interface. Samples `d_valid`/`out_data`/`err_code`/`fin` every cycle, queues each result with a sequence tag in a small FIFO, keeps per-category counters, and presents records to a host over a valid/ready handshake. It raises `done` once the program has finished and every queued record has been delivered.

## Interface
- `DEPTH`, 8: FIFO entries (power of two, at least 2).
- `DATA_W`, 20: result width; must match the stack machine's `out_data`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_valid` in 1: a result or error is present this cycle.
- `out_data` in DATA_W: result value (two's complement).
- `err_code` in 3: 000 ok, 001 stack error, 010 undefined opcode, 100 operand restore.
- `fin` in 1: program counter has reached program length (level).
- `o_valid` out 1: head record available.
- `o_ready` in 1: host accepts the head record.
- `o_data` out DATA_W: head record value.
- `o_err` out 3: head record `err_code`.
- `o_seq` out 8: head record sequence tag.
- `ok_cnt`, `stk_cnt`, `und_cnt`, `rst_cnt` out 8 each: saturating category counters.
- `drop_cnt` out 8: saturating count of results lost to a full FIFO.
- `done` out 1: program finished and FIFO drained.
- `chksum` out DATA_W: running checksum (see Configuration).

## Operation
- Every output resets to 0, and the FSM resets to RUN.
- Capture happens on each cycle with `d_valid=1`:
  - `seq` increments mod 256, whether or not the result is stored.
  - Category counters are updated: code 000 increments `ok_cnt`, 001 `stk_cnt`, 100 `rst_cnt`. Code 010 and any other nonzero code increment `und_cnt`.
  - All counters hold at 255 (no wrap).
- Store: `{out_data, err_code, seq}` is written if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Drop: when the FIFO is full and there is no pop, the record is discarded and `drop_cnt` increments. The sequence gap is therefore visible to the host.
- Pop: a pop occurs when `o_valid && o_ready`. There is no bypass, so an empty FIFO never pops.
- The FSM has three states:
  - RUN: `fin=1` moves to DRAIN.
  - DRAIN: FIFO empty and no push this cycle moves to DONE.
  - DONE: `done=1`. A later `d_valid` returns the FSM to DRAIN, and `done` drops on the next cycle.
- `fin` is sticky once sampled: the FSM never returns to RUN except through `rst`.
- `rst` asserted mid-stream clears the FIFO, pointers, counters, `seq`, and the checksum on the next edge. Records in flight are lost, and none are reported as drops.

## Timing
- A `d_valid` at edge N is visible as `o_valid=1` after edge N (latency 1).
- `o_data`, `o_err` and `o_seq` are driven from registered storage and are stable while `o_valid && !o_ready`.
- Push and pop in the same cycle at full occupancy: occupancy stays at DEPTH, no drop.
- Counters and `drop_cnt` update one edge after the sampled `d_valid`.
- `done` asserts one edge after the FIFO becomes empty with the FSM in DRAIN. Minimum `fin`-to-`done` time with an empty FIFO is 2 edges.
- Pointers are log2(DEPTH) bits plus one wrap bit:
  - Full is flagged when the pointers differ only in the wrap bit.
  - Empty is flagged when the pointers are equal.

## Configuration
- Macro: `SM_RESULT_COLLECTOR_CHKSUM_EN`.
- Defined: `chksum` accumulates `chksum + out_data` (mod 2^DATA_W) for every `d_valid` with `err_code==000`, including dropped ones, and resets to 0.
- Undefined: no accumulator is built and `chksum` is tied to 0.

## Structure
- Shared package `sm_result_pkg` holds:
  - Error-code constants: `ERR_OK`=000, `ERR_STK`=001, `ERR_UND`=010, `ERR_RESTORE`=100.
  - FSM state encoding: RUN, DRAIN, DONE.
  - Record width constant: DATA_W+3+8.
- One sub-module, `sm_result_fifo`: parameterised synchronous FIFO with push, pop, full, empty and registered storage.
- The top level owns the FSM, counters, sequence tag and checksum.

## Test plan
- Three ok results (5, -3 = 0xFFFFD, 42) with `o_ready=1`:
  - Records appear with `seq` 0, 1, 2 one cycle after each input.
  - `ok_cnt=3`.
  - With `CHKSUM_EN`, `chksum`=0x0002C.
- `o_ready=0` and 10 back-to-back ok results:
  - 8 are stored (`seq` 0–7) and `drop_cnt=2`.
  - Then raising `o_ready` delivers 0–7 in order, and a new input gets `seq`=10.
- Full FIFO with simultaneous push and pop: no drop, and occupancy stays at 8.
- Error codes 001, 010, 100, then 111:
  - `stk_cnt=1`, `rst_cnt=1`, `und_cnt=2`.
  - `o_err` values match the inputs in order.
- `fin` asserted with 2 records queued and `o_ready=1`: `done` rises one edge after the queue empties. A later `d_valid` drops `done` and re-delivers.
- 300 ok results with `o_ready=1`:
  - `ok_cnt` saturates at 255.
  - `o_seq` wraps 255 to 0.
  - `rst` mid-stream zeroes all outputs on the next edge.
